// File: rtl/exec_sequencer.sv
// exec_sequencer
//
// Purpose:
//   Sits between the decoder and a multi-cycle ALU. Accepts one operation
//   through a valid/ready handshake and registers its operands and opcode
//   toward the ALU. It optionally replaces operand B with an extended
//   immediate, and issues a one-cycle alu_start pulse. It then waits a fixed
//   latency, which depends on the opcode, before capturing alu_result. The
//   captured result, plus an optional PC-relative jump target, is presented
//   to writeback until writeback consumes it.
//
// Parameters:
//   ALU_LATENCY     cycles from alu_start to valid alu_result, single-cycle ops (1..63)
//   MULDIV_LATENCY  cycles from alu_start to valid alu_result, opcodes 4'hE/4'hF (1..63)
//
// Ports:
//   CLOCK_50, reset_n                      clock (rising edge), async active-low reset
//   in_valid / in_ready                    decoder handshake
//   alu_A, alu_B, immediate                operand sources
//   select_immediate, sign_extend          operand B selection and immediate extension
//   alu_opcode, is_jump                    operation and jump flag
//   program_counter, pc_increment_jump     PC and signed 27-bit jump offset
//   alu_A_out, alu_B_out, alu_opcode_out   registered operands to the ALU
//   alu_start / alu_result                 ALU launch pulse and ALU output
//   out_valid / out_ready, result          writeback handshake and captured result
//   pc_jump_valid, program_counter_jumped  jump target and its qualifier
//   busy                                   high whenever the sequencer is not idle

module exec_sequencer #(
  parameter int ALU_LATENCY    = 1,
  parameter int MULDIV_LATENCY = 32
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_A,
  input  logic [31:0] alu_B,
  input  logic [26:0] immediate,
  input  logic        select_immediate,
  input  logic        sign_extend,
  input  logic [3:0]  alu_opcode,
  input  logic        is_jump,
  input  logic [31:0] program_counter,
  input  logic [26:0] pc_increment_jump,
  output logic [31:0] alu_A_out,
  output logic [31:0] alu_B_out,
  output logic [3:0]  alu_opcode_out,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        pc_jump_valid,
  output logic [31:0] program_counter_jumped,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // The counter is loaded with N-1, so EXEC lasts exactly N cycles.
  localparam logic [5:0] ALU_LOAD    = 6'(ALU_LATENCY - 1);
  localparam logic [5:0] MULDIV_LOAD = 6'(MULDIV_LATENCY - 1);

  state_t      state;
  logic [5:0]  lat_count;
  logic        jump_pending;
  logic        transfer;
  logic [31:0] imm_ext;
  logic [31:0] jump_target;
  logic [5:0]  first_count;

  // in_ready is held low while reset is asserted, even though the state is already IDLE.
  assign in_ready = reset_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign transfer = in_valid && in_ready;
  assign busy     = (state != IDLE);

  assign imm_ext     = {(sign_extend ? {5{immediate[26]}} : 5'b0), immediate};
  assign jump_target = program_counter + {{5{pc_increment_jump[26]}}, pc_increment_jump};

  // The opcode seen on the transfer edge is the one being captured, so its
  // latency choice is identical to one made from alu_opcode_out afterward.
  assign first_count = ((alu_opcode == 4'hE) || (alu_opcode == 4'hF)) ? MULDIV_LOAD : ALU_LOAD;

  // Sequencer state machine.
  // A transfer in IDLE or DONE overrides the DONE->IDLE path. This gives
  // zero-bubble back-to-back operation.
  // alu_result is captured on the edge that ends the last EXEC cycle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      lat_count              <= '0;
      jump_pending           <= 1'b0;
      alu_A_out              <= '0;
      alu_B_out              <= '0;
      alu_opcode_out         <= '0;
      alu_start              <= 1'b0;
      out_valid              <= 1'b0;
      result                 <= '0;
      pc_jump_valid          <= 1'b0;
      program_counter_jumped <= '0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
        end
        EXEC: begin
          if (lat_count == '0) begin
            result        <= alu_result;
            out_valid     <= 1'b1;
            pc_jump_valid <= jump_pending;
            state         <= DONE;
          end else begin
            lat_count <= lat_count - 6'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            pc_jump_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (transfer) begin
        alu_A_out              <= alu_A;
        alu_B_out              <= select_immediate ? imm_ext : alu_B;
        alu_opcode_out         <= alu_opcode;
        alu_start              <= 1'b1;
        lat_count              <= first_count;
        jump_pending           <= is_jump;
        program_counter_jumped <= is_jump ? jump_target : 32'd0;
        state                  <= EXEC;
      end
    end
  end

endmodule
